// File: rtl/vc_fifo_buffer_if.sv
// Push/pull/status bundle for the multi-VC input buffer.
// master: link side + allocator side (drives push/pull/flush); slave: the buffer.
interface vc_fifo_buffer_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int NUM_VC = 2
);
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic                     push;
  logic [VCW-1:0]           push_vc;
  logic [WIDTH-1:0]         tail;
  logic                     pull;
  logic [VCW-1:0]           pull_vc;
  logic [NUM_VC-1:0]        flush;
  logic                     err_clear;
  logic [NUM_VC*WIDTH-1:0]  head;
  logic [NUM_VC*CW-1:0]     counter;
  logic [NUM_VC-1:0]        empty;
  logic [NUM_VC-1:0]        full;
  logic [NUM_VC-1:0]        almost_full;
  logic                     overflow_err;
  logic                     underflow_err;

  modport master (
    output push, push_vc, tail,
    output pull, pull_vc, flush, err_clear,
    input  head, counter, empty, full,
    input  almost_full, overflow_err, underflow_err
  );

  modport slave (
    input  push, push_vc, tail,
    input  pull, pull_vc, flush, err_clear,
    output head, counter, empty, full,
    output almost_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_fifo_buffer.sv
// NUM_VC independent circular flit queues (DEPTH each, any DEPTH >= 2).
// Ports: clock, reset (async active-low), bus (slave: push/pull/flush in, status out).
module vc_fifo_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_VC    = 2,
  parameter int AF_THRESH = DEPTH - 1
) (
  input logic             clock,
  input logic             reset,
  vc_fifo_buffer_if.slave bus
);
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [WIDTH-1:0] mem [NUM_VC][DEPTH];
  ptr_t rd_ptr [NUM_VC];
  ptr_t wr_ptr [NUM_VC];
  cnt_t cnt    [NUM_VC];
  logic ovf_q;
  logic unf_q;

  logic [NUM_VC-1:0] pull_hit;
  logic [NUM_VC-1:0] push_hit;
  logic push_drop;
  logic pull_drop;

  function automatic ptr_t nxt(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // An out-of-range VC matches no lane, so it falls into the drop/error path.
  // A full VC still accepts a push when it is pulled in the same cycle.
  always_comb begin
    pull_hit = '0;
    push_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pull_hit[v] = bus.pull && (bus.pull_vc == VCW'(v))
                    && (cnt[v] != '0);
      push_hit[v] = bus.push && (bus.push_vc == VCW'(v))
                    && ((cnt[v] != cnt_t'(DEPTH)) || pull_hit[v]);
    end
    push_drop = bus.push && (push_hit == '0);
    pull_drop = bus.pull && (pull_hit == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (bus.flush[v]) begin
          rd_ptr[v] <= '0;
          wr_ptr[v] <= '0;
          cnt[v]    <= '0;
        end else begin
          if (pull_hit[v]) rd_ptr[v] <= nxt(rd_ptr[v]);
          if (push_hit[v]) wr_ptr[v] <= nxt(wr_ptr[v]);
          unique case ({push_hit[v], pull_hit[v]})
            2'b10:   cnt[v] <= cnt[v] + cnt_t'(1);
            2'b01:   cnt[v] <= cnt[v] - cnt_t'(1);
            default: cnt[v] <= cnt[v];
          endcase
        end
      end
      // A fresh error outranks a clear in the same cycle.
      if (push_drop)          ovf_q <= 1'b1;
      else if (bus.err_clear) ovf_q <= 1'b0;
      if (pull_drop)          unf_q <= 1'b1;
      else if (bus.err_clear) unf_q <= 1'b0;
    end
  end

  // Flit storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_hit[v] && !bus.flush[v])
        mem[v][wr_ptr[v]] <= bus.tail;
    end
  end

  // Outputs depend only on registered state.
  always_comb begin
    bus.head        = '0;
    bus.counter     = '0;
    bus.empty       = '0;
    bus.full        = '0;
    bus.almost_full = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      bus.head[v*WIDTH +: WIDTH] = mem[v][rd_ptr[v]];
      bus.counter[v*CW +: CW]    = cnt[v];
      bus.empty[v]       = (cnt[v] == '0);
      bus.full[v]        = (cnt[v] == cnt_t'(DEPTH));
      bus.almost_full[v] = (cnt[v] >= cnt_t'(AF_THRESH));
    end
    bus.overflow_err  = ovf_q;
    bus.underflow_err = unf_q;
  end
endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Bench for vc_fifo_buffer: queue scoreboard on an 8x8x2 build,
// plus 5-deep builds with 4 and 3 VCs for flush and VC-range cases.
module tb_vc_fifo_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vc_fifo_buffer_if #(.WIDTH(8), .DEPTH(8), .NUM_VC(2)) a_if ();
  vc_fifo_buffer_if #(.WIDTH(8), .DEPTH(5), .NUM_VC(4)) b_if ();
  vc_fifo_buffer_if #(.WIDTH(8), .DEPTH(5), .NUM_VC(3)) c_if ();

  vc_fifo_buffer #(.WIDTH(8), .DEPTH(8), .NUM_VC(2)) dut_a (
    .clock(clk), .reset(rst_n), .bus(a_if.slave));
  vc_fifo_buffer #(.WIDTH(8), .DEPTH(5), .NUM_VC(4)) dut_b (
    .clock(clk), .reset(rst_n), .bus(b_if.slave));
  vc_fifo_buffer #(.WIDTH(8), .DEPTH(5), .NUM_VC(3)) dut_c (
    .clock(clk), .reset(rst_n), .bus(c_if.slave));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for instance A: one queue per VC.
  logic [7:0] mq [2][$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  task automatic a_check();
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("a_cnt%0d", v), a_if.counter[v*4 +: 4], mq[v].size());
      chk($sformatf("a_empty%0d", v), a_if.empty[v], mq[v].size() == 0);
      chk($sformatf("a_full%0d", v), a_if.full[v], mq[v].size() == 8);
      chk($sformatf("a_af%0d", v), a_if.almost_full[v], mq[v].size() >= 7);
    end
    chk("a_ovf", a_if.overflow_err, m_ovf);
    chk("a_unf", a_if.underflow_err, m_unf);
  endtask

  task automatic a_cyc(input logic p, input logic pv, input logic [7:0] t,
                       input logic l, input logic lv,
                       input logic [1:0] fl, input logic ec);
    bit pull_ok;
    bit push_ok;
    a_if.push = p; a_if.push_vc = pv; a_if.tail = t;
    a_if.pull = l; a_if.pull_vc = lv;
    a_if.flush = fl; a_if.err_clear = ec;
    #1;
    pull_ok = l && (mq[lv].size() > 0);
    if (pull_ok)
      chk("a_head", a_if.head[int'(lv)*8 +: 8], mq[lv][0]);
    push_ok = p && ((mq[pv].size() < 8) || (pull_ok && lv == pv));
    @(posedge clk);
    if (pull_ok) void'(mq[lv].pop_front());
    if (push_ok) mq[pv].push_back(t);
    for (int v = 0; v < 2; v++) if (fl[v]) mq[v].delete();
    if (p && !push_ok) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
    if (l && !pull_ok) m_unf = 1'b1; else if (ec) m_unf = 1'b0;
    #1;
    a_if.push = 0; a_if.pull = 0; a_if.flush = 0; a_if.err_clear = 0;
    a_check();
  endtask

  typedef struct {
    logic p; logic pv; logic [7:0] t;
    logic l; logic lv; logic ec;
    int c1; logic ovf; logic unf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic p, logic pv, logic [7:0] t, logic l,
                              logic lv, logic ec, int c1, logic ovf, logic unf);
    vec_t r;
    r.p = p; r.pv = pv; r.t = t; r.l = l; r.lv = lv; r.ec = ec;
    r.c1 = c1; r.ovf = ovf; r.unf = unf;
    return r;
  endfunction

  task automatic b_push(input logic [1:0] vc, input logic [7:0] t,
                        input logic [3:0] fl);
    b_if.push = 1; b_if.push_vc = vc; b_if.tail = t; b_if.flush = fl;
    @(posedge clk); #1;
    b_if.push = 0; b_if.flush = 0;
  endtask

  task automatic c_op(input logic p, input logic [1:0] pv,
                      input logic l, input logic [1:0] lv);
    c_if.push = p; c_if.push_vc = pv; c_if.tail = 8'h3C;
    c_if.pull = l; c_if.pull_vc = lv;
    @(posedge clk); #1;
    c_if.push = 0; c_if.pull = 0;
  endtask

  initial begin
    a_if.push = 0; a_if.push_vc = 0; a_if.tail = 0; a_if.pull = 0;
    a_if.pull_vc = 0; a_if.flush = 0; a_if.err_clear = 0;
    b_if.push = 0; b_if.push_vc = 0; b_if.tail = 0; b_if.pull = 0;
    b_if.pull_vc = 0; b_if.flush = 0; b_if.err_clear = 0;
    c_if.push = 0; c_if.push_vc = 0; c_if.tail = 0; c_if.pull = 0;
    c_if.pull_vc = 0; c_if.flush = 0; c_if.err_clear = 0;

    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 1, 8'h10 + 8'(i), 0, 0, 0, i + 1, 0, 0));
    tbl.push_back(mk(1, 1, 8'h99, 0, 0, 0, 8, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 7 - i, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    a_check();

    foreach (tbl[i]) begin
      a_cyc(tbl[i].p, tbl[i].pv, tbl[i].t, tbl[i].l, tbl[i].lv,
            2'b00, tbl[i].ec);
      chk($sformatf("tbl%0d_c1", i), a_if.counter[4 +: 4], tbl[i].c1);
      chk($sformatf("tbl%0d_ovf", i), a_if.overflow_err, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), a_if.underflow_err, tbl[i].unf);
    end

    // Second pass on VC1 exercises pointer wrap.
    for (int i = 0; i < 8; i++) a_cyc(1, 1, 8'h20 + 8'(i), 0, 0, 0, 0);
    chk("wrap_full1", a_if.full[1], 1);
    for (int i = 0; i < 8; i++) a_cyc(0, 0, 0, 1, 1, 0, 0);
    chk("wrap_empty1", a_if.empty[1], 1);

    // VC0 full, push+pull same cycle; 0xAA comes out last.
    for (int i = 0; i < 8; i++) a_cyc(1, 0, 8'hC0 + 8'(i), 0, 0, 0, 0);
    a_cyc(1, 0, 8'hAA, 1, 0, 0, 0);
    chk("pp_cnt0", a_if.counter[0 +: 4], 8);
    chk("pp_ovf", a_if.overflow_err, 0);
    for (int i = 0; i < 7; i++) a_cyc(0, 0, 0, 1, 0, 0, 0);
    chk("pp_last", a_if.head[0 +: 8], 8'hAA);
    a_cyc(0, 0, 0, 1, 0, 0, 0);

    // Different VCs in one cycle act independently.
    a_cyc(1, 1, 8'h41, 0, 0, 0, 0);
    a_cyc(1, 0, 8'h42, 1, 1, 0, 0);
    a_cyc(1, 1, 8'h43, 1, 0, 0, 0);
    a_cyc(0, 0, 0, 0, 0, 2'b10, 0);

    // Flush on 4 VCs, DEPTH=5.
    for (int i = 0; i < 3; i++) b_push(2, 8'h51 + 8'(i), 4'b0000);
    for (int i = 0; i < 2; i++) b_push(3, 8'h61 + 8'(i), 4'b0000);
    chk("b_c2_pre", b_if.counter[8 +: 4], 3);
    chk("b_c3_pre", b_if.counter[12 +: 4], 2);
    b_push(2, 8'h77, 4'b0100);
    chk("b_c2_flush", b_if.counter[8 +: 4], 0);
    chk("b_e2_flush", b_if.empty[2], 1);
    chk("b_c3_keep", b_if.counter[12 +: 4], 2);
    chk("b_h3_keep", b_if.head[24 +: 8], 8'h61);
    b_push(2, 8'h88, 4'b0000);
    chk("b_h2_new", b_if.head[16 +: 8], 8'h88);
    for (int i = 0; i < 4; i++) b_push(0, 8'(i), 4'b0000);
    chk("b_af0", b_if.almost_full[0], 1);
    chk("b_full0_4", b_if.full[0], 0);
    b_push(0, 8'h04, 4'b0000);
    chk("b_full0_5", b_if.full[0], 1);
    chk("b_c0_5", b_if.counter[0 +: 4], 5);

    // Out-of-range VC on a 3-VC build.
    c_op(1, 2, 0, 0);
    c_op(1, 3, 0, 0);
    chk("c_ovf", c_if.overflow_err, 1);
    chk("c_unf0", c_if.underflow_err, 0);
    chk("c_cnt", c_if.counter, {4'd1, 4'd0, 4'd0});
    c_op(0, 0, 1, 3);
    chk("c_unf", c_if.underflow_err, 1);
    chk("c_cnt2", c_if.counter[8 +: 4], 1);

    // Async reset in the middle of traffic.
    a_cyc(1, 0, 8'h01, 0, 0, 0, 0);
    a_cyc(1, 1, 8'h02, 1, 0, 0, 0);
    a_cyc(0, 0, 0, 1, 0, 0, 0);
    chk("pre_rst_unf", a_if.underflow_err, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_cnt", a_if.counter, 0);
    chk("rst_empty", a_if.empty, 2'b11);
    chk("rst_full", a_if.full, 0);
    chk("rst_af", a_if.almost_full, 0);
    chk("rst_errs", {a_if.overflow_err, a_if.underflow_err}, 0);
    chk("rst_b_cnt", b_if.counter, 0);
    chk("rst_c_ovf", c_if.overflow_err, 0);
    mq[0].delete(); mq[1].delete();
    m_ovf = 0; m_unf = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    a_cyc(1, 0, 8'h5A, 0, 0, 0, 0);
    a_cyc(0, 0, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
